// File: rtl/header_stream_ctrl_pkg.sv
// header_pkg: shared types and constants for the block-header streaming controller.
// Holds the controller state enum, the header word geometry and the word that
// `sel` reloads to at the start of every pass after the first one.
// Build option: HDR_MIDSTATE_SKIP_EN (reload to the second block instead of word 0).
package header_pkg;

  localparam int unsigned NUM_WORDS   = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned NONCE_WORD  = 19;
  localparam int unsigned NONCE_W     = 32;

`ifdef HDR_MIDSTATE_SKIP_EN
  // Block 0 has no nonce, so its midstate is reused and only block 1 is resent.
  localparam int unsigned RELOAD_WORD = BLOCK_WORDS;
`else
  localparam int unsigned RELOAD_WORD = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_WAIT_HASH = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/header_stream_ctrl_if.sv
// header_stream_ctrl_if: control, word-stream and status signals between the
// nonce-search controller and its environment (host + SHA core).
//   master : the controller (drives sel/word_valid/nonce/status)
//   slave  : the environment (drives start/abort/range/word_ready/hash results)
interface header_stream_ctrl_if #(
  parameter int unsigned SEL_W = 5
);
  logic                             start;
  logic                             abort;
  logic [header_pkg::NONCE_W-1:0]   nonce_start;
  logic [header_pkg::NONCE_W-1:0]   nonce_end;
  logic                             word_ready;
  logic                             hash_done;
  logic                             hash_hit;
  logic [SEL_W-1:0]                 sel;
  logic                             word_valid;
  logic                             block_last;
  logic                             nonce_sel;
  logic [header_pkg::NONCE_W-1:0]   nonce;
  logic                             busy;
  logic                             done;
  logic                             found;

  modport master (
    input  start, abort, nonce_start, nonce_end, word_ready, hash_done, hash_hit,
    output sel, word_valid, block_last, nonce_sel, nonce, busy, done, found
  );

  modport slave (
    output start, abort, nonce_start, nonce_end, word_ready, hash_done, hash_hit,
    input  sel, word_valid, block_last, nonce_sel, nonce, busy, done, found
  );
endinterface

// File: rtl/header_stream_ctrl_nonce_counter.sv
// nonce_counter: current nonce register, its modulo-2^32 increment and the
// compare against the latched (inclusive) end of the search range.
//   clk, rst_n     : clock, async active-low reset
//   load_i         : latch start_val_i as nonce and end_val_i as range end
//   inc_i          : advance nonce by one (wraps 0xFFFFFFFF -> 0)
//   nonce_o        : registered current nonce
//   at_end_c       : nonce equals the latched range end (combinational)
module nonce_counter
  import header_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [NONCE_W-1:0] start_val_i,
  input  logic [NONCE_W-1:0] end_val_i,
  input  logic               inc_i,
  output logic [NONCE_W-1:0] nonce_o,
  output logic               at_end_c
);

  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] end_q, end_d;

  // Load has priority; the controller never asserts both together.
  always_comb begin
    nonce_d = nonce_q;
    end_d   = end_q;
    if (load_i) begin
      nonce_d = start_val_i;
      end_d   = end_val_i;
    end else if (inc_i) begin
      nonce_d = NONCE_W'(nonce_q + NONCE_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_q <= '0;
      end_q   <= '0;
    end else begin
      nonce_q <= nonce_d;
      end_q   <= end_d;
    end
  end

  assign nonce_o  = nonce_q;
  assign at_end_c = (nonce_q == end_q);

endmodule

// File: rtl/header_stream_ctrl.sv
// header_stream_ctrl: walks a nonce range, streaming the padded 80-byte header
// (NUM_WORDS words) to a SHA-256 core once per nonce and stopping on a hit or
// at the end of the range.
//   clock, reset_n : clock, async active-low reset
//   bus (master)   : start/abort/range in, word-select stream to the core,
//                    hash results in, nonce and busy/done/found status out
// Build option: HDR_MIDSTATE_SKIP_EN -- later passes restart at word 16.
module header_stream_ctrl #(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned SEL_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  header_stream_ctrl_if.master bus
);
  import header_pkg::*;

  localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(NUM_WORDS - 1);
  localparam logic [SEL_W-1:0] BLK_LAST_SEL = SEL_W'(BLOCK_WORDS - 1);
  localparam logic [SEL_W-1:0] NONCE_SEL    = SEL_W'(NONCE_WORD);
  localparam logic [SEL_W-1:0] RELOAD_SEL   = SEL_W'(RELOAD_WORD);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               word_valid_q, word_valid_d;
  logic               block_last_q, block_last_d;
  logic               nonce_sel_q, nonce_sel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic               nonce_load, nonce_inc;
  logic               at_end;
  logic [NONCE_W-1:0] nonce;

  nonce_counter u_nonce_counter (
    .clk         (clock),
    .rst_n       (reset_n),
    .load_i      (nonce_load),
    .start_val_i (bus.nonce_start),
    .end_val_i   (bus.nonce_end),
    .inc_i       (nonce_inc),
    .nonce_o     (nonce),
    .at_end_c    (at_end)
  );

  // Next-state and next-output logic; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    word_valid_d = word_valid_q;
    done_d       = done_q;
    found_d      = found_q;
    nonce_load   = 1'b0;
    nonce_inc    = 1'b0;

    if (bus.abort) begin
      state_d      = ST_IDLE;
      sel_d        = '0;
      word_valid_d = 1'b0;
      done_d       = 1'b0;
      found_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d      = ST_STREAM;
            sel_d        = '0;
            word_valid_d = 1'b1;
            done_d       = 1'b0;
            found_d      = 1'b0;
            nonce_load   = 1'b1;
          end
        end
        ST_STREAM: begin
          if (word_valid_q && bus.word_ready) begin
            if (sel_q == LAST_SEL) begin
              state_d      = ST_WAIT_HASH;
              word_valid_d = 1'b0;
            end else begin
              sel_d = SEL_W'(sel_q + SEL_W'(1));
            end
          end
        end
        ST_WAIT_HASH: begin
          if (bus.hash_done) begin
            if (bus.hash_hit || at_end) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              found_d = bus.hash_hit;
            end else begin
              state_d      = ST_STREAM;
              sel_d        = RELOAD_SEL;
              word_valid_d = 1'b1;
              nonce_inc    = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Decoded status is computed from the next state so it stays registered.
    busy_d       = (state_d == ST_STREAM) || (state_d == ST_WAIT_HASH);
    block_last_d = word_valid_d && ((sel_d == BLK_LAST_SEL) || (sel_d == LAST_SEL));
    nonce_sel_d  = (sel_d == NONCE_SEL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      word_valid_q <= 1'b0;
      block_last_q <= 1'b0;
      nonce_sel_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      word_valid_q <= word_valid_d;
      block_last_q <= block_last_d;
      nonce_sel_q  <= nonce_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      found_q      <= found_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.word_valid = word_valid_q;
  assign bus.block_last = block_last_q;
  assign bus.nonce_sel  = nonce_sel_q;
  assign bus.nonce      = nonce;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.found      = found_q;

endmodule

// File: tb/tb_header_stream_ctrl.sv
// Scoreboard bench for header_stream_ctrl: a reference model expands each
// search into the expected (nonce, word) transfer list and final result; a
// responder emulates the SHA core; a monitor checks every transfer and result.
module tb_header_stream_ctrl;
  localparam int unsigned SEL_W = 5;
  localparam int          NW    = 32;
`ifdef HDR_MIDSTATE_SKIP_EN
  localparam int          RELOAD = 16;
`else
  localparam int          RELOAD = 0;
`endif

  typedef struct { logic [31:0] nonce; int sel; } word_t;
  typedef struct { bit found; logic [31:0] nonce; } res_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  header_stream_ctrl_if #(.SEL_W(SEL_W)) bus();

  header_stream_ctrl #(.NUM_WORDS(NW), .SEL_W(SEL_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  word_t exp_words[$];
  res_t  exp_res[$];
  int    checks = 0;
  int    failures = 0;
  int    hit_pass = -1;
  int    ready_mode = 0;
  bit    spurious_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: one pass per nonce, pass 0 sends all words, later passes
  // start at RELOAD; stop on the hit pass or after the end nonce.
  task automatic push_model(input logic [31:0] s, input logic [31:0] e, input int hp);
    logic [31:0] n;
    res_t r;
    word_t w;
    n = s;
    r.found = 1'b0;
    for (int p = 0; p < 64; p++) begin
      for (int k = (p == 0) ? 0 : RELOAD; k < NW; k++) begin
        w.nonce = n;
        w.sel   = k;
        exp_words.push_back(w);
      end
      if (p == hp) begin
        r.found = 1'b1;
        break;
      end
      if (n == e) break;
      n = n + 32'd1;
    end
    r.nonce = n;
    exp_res.push_back(r);
  endtask

  // SHA-core emulation: word_ready pattern and hash results.
  int hash_wait = 0;
  int pass_idx = 0;
  int stall_cnt = 0;
  initial begin
    bus.word_ready = 1'b0;
    bus.hash_done  = 1'b0;
    bus.hash_hit   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n || bus.abort) begin
        hash_wait = 0;
      end else if (bus.start && !bus.busy) begin
        pass_idx  = 0;
        hash_wait = 0;
        stall_cnt = 0;
      end else if (bus.word_valid && bus.word_ready && bus.sel == SEL_W'(NW - 1)) begin
        hash_wait = $urandom_range(1, 4);
      end
      @(posedge clock);
      #1;
      bus.hash_done = 1'b0;
      bus.hash_hit  = 1'b0;
      if (hash_wait > 0) begin
        hash_wait--;
        if (hash_wait == 0) begin
          bus.hash_done = 1'b1;
          bus.hash_hit  = (pass_idx == hit_pass);
          pass_idx++;
        end
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        bus.hash_done = 1'b1;
        bus.hash_hit  = 1'($urandom);
      end
      case (ready_mode)
        1: bus.word_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.word_valid && bus.sel == SEL_W'(7) && stall_cnt < 3) begin
            bus.word_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.word_ready = 1'b1;
          end
        end
        default: bus.word_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pop and compare on every transfer and on every rising done.
  initial begin
    bit prev_done;
    word_t w;
    res_t r;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && bus.word_valid && bus.word_ready) begin
        if (exp_words.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          w = exp_words.pop_front();
          check("word_sel", 64'(bus.sel), 64'(w.sel));
          check("word_nonce", 64'(bus.nonce), 64'(w.nonce));
          check("block_last", 64'(bus.block_last), 64'(w.sel == 15 || w.sel == 31));
          check("nonce_sel", 64'(bus.nonce_sel), 64'(w.sel == 19));
        end
      end
      if (reset_n && bus.done && !prev_done) begin
        if (exp_res.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          r = exp_res.pop_front();
          check("result_found", 64'(bus.found), 64'(r.found));
          check("result_nonce", 64'(bus.nonce), 64'(r.nonce));
          check("result_busy", 64'(bus.busy), 64'd0);
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!bus.done) fail_now("done_timeout");
    repeat (2) @(negedge clock);
    check("words_left", 64'(exp_words.size()), 64'd0);
    check("results_left", 64'(exp_res.size()), 64'd0);
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] e);
    bus.nonce_start = s;
    bus.nonce_end   = e;
    @(posedge clock); #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    // Range must have been latched; scramble the inputs.
    bus.nonce_start = $urandom;
    bus.nonce_end   = $urandom;
    @(negedge clock);
    check("start_valid", 64'(bus.word_valid), 64'd1);
    check("start_sel", 64'(bus.sel), 64'd0);
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_done_clr", 64'(bus.done), 64'd0);
    check("start_found_clr", 64'(bus.found), 64'd0);
  endtask

  task automatic run_search(input logic [31:0] s, input logic [31:0] e, input int hp,
                            input int mode, input bit poke);
    int n;
    push_model(s, e, hp);
    hit_pass   = hp;
    ready_mode = mode;
    pulse_start(s, e);
    if (mode == 0) begin
      n = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (!bus.word_valid) break;
        n++;
      end
      check("pass_cycles", 64'(n), 64'(NW));
    end else if (poke) begin
      repeat (4) @(posedge clock);
      #1;
      bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    wait_done(1500);
  endtask

  task automatic cancel_test(input bit use_reset);
    bit seen;
    push_model(32'd0, 32'd3, -1);
    hit_pass   = -1;
    ready_mode = 0;
    pulse_start(32'd0, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.word_valid && bus.sel == SEL_W'(10)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) fail_now("sel10_timeout");
    @(posedge clock); #1;
    if (use_reset) reset_n = 1'b0;
    else bus.abort = 1'b1;
    if (!use_reset) begin
      @(posedge clock); #1;
      bus.abort = 1'b0;
    end
    @(negedge clock);
    check(use_reset ? "rst_valid" : "abort_valid", 64'(bus.word_valid), 64'd0);
    check(use_reset ? "rst_busy" : "abort_busy", 64'(bus.busy), 64'd0);
    check(use_reset ? "rst_done" : "abort_done", 64'(bus.done), 64'd0);
    check(use_reset ? "rst_found" : "abort_found", 64'(bus.found), 64'd0);
    check(use_reset ? "rst_sel" : "abort_sel", 64'(bus.sel), 64'd0);
    if (use_reset) check("rst_nonce", 64'(bus.nonce), 64'd0);
    exp_words.delete();
    exp_res.delete();
  endtask

  initial begin
    logic [31:0] s;
    int len;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.nonce_start = '0;
    bus.nonce_end   = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_sel", 64'(bus.sel), 64'd0);
    check("reset_nonce", 64'(bus.nonce), 64'd0);
    check("reset_valid", 64'(bus.word_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_found", 64'(bus.found), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    run_search(32'd5, 32'd5, -1, 0, 1'b0);
    check("single_done", 64'(bus.done), 64'd1);
    run_search(32'd0, 32'd0, -1, 2, 1'b0);
    spurious_en = 1'b1;
    run_search(32'd0, 32'd2, 1, 0, 1'b0);
    run_search(32'hFFFF_FFFF, 32'h0000_0000, -1, 1, 1'b1);
    run_search(32'd0, 32'd1, -1, 1, 1'b0);
    run_search(32'd40, 32'd50, 0, 2, 1'b1);

    // abort wins over a simultaneous start from DONE
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clock);
    check("abort_pri_valid", 64'(bus.word_valid), 64'd0);
    check("abort_pri_busy", 64'(bus.busy), 64'd0);
    check("abort_pri_done", 64'(bus.done), 64'd0);

    cancel_test(1'b0);
    cancel_test(1'b1);

    // start is taken on the first edge after reset release
    push_model(32'd7, 32'd8, 1);
    hit_pass   = 1;
    ready_mode = 1;
    bus.nonce_start = 32'd7;
    bus.nonce_end   = 32'd8;
    @(posedge clock); #1;
    reset_n   = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(negedge clock);
    check("post_reset_valid", 64'(bus.word_valid), 64'd1);
    check("post_reset_nonce", 64'(bus.nonce), 64'd7);
    wait_done(1500);

    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       s = $urandom;
        1:       s = 32'hFFFF_FFFE;
        default: s = 32'd0;
      endcase
      len = $urandom_range(1, 3);
      run_search(s, s + 32'(len - 1), $urandom_range(0, 3), $urandom_range(1, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
